tdm_chan_accum: RTL

Per-channel burst accumulator that sits directly downstream of the round-robin TDM multiply stage. It takes the interleaved product stream (one product per fast-clock cycle, channels in fixed rotation 0,1,…,N-1), de-interleaves it by an internal channel counter aligned to a frame marker, and sums BURST_LEN products per channel. Each completed channel sum is queued in a small FIFO and presented on a valid/ready output.

---
 rtl/tdm_chan_accum.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tdm_chan_accum.sv
`default_nettype none
// ============================================================================
// Module   : tdm_chan_accum
// Brief    : De-interleaves a round-robin TDM product stream, sums BURST_LEN
//            products per channel and queues each channel sum in a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_chan_accum #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 2,
    parameter int BURST_LEN    = 16,
    parameter int ACC_WIDTH    = 24,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_first,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ACC_WIDTH-1:0]            out_data,
    output logic [$clog2(NUM_CHANNELS)-1:0] out_chan,
    output logic                            aligned,
    output logic                            overflow,
    output logic                            sync_err
);

    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int NW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [0:0] S_ALIGN = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    generate
        if (ACC_WIDTH < DATA_WIDTH + $clog2(BURST_LEN)) begin : g_width_check
            $error("tdm_chan_accum: ACC_WIDTH too small for DATA_WIDTH and BURST_LEN");
        end
    endgenerate

    logic [0:0]           r_state;
    logic [CW-1:0]        r_ch;
    logic [ACC_WIDTH-1:0] r_acc [NUM_CHANNELS];
    logic [NW-1:0]        r_cnt [NUM_CHANNELS];
    logic                 r_overflow;
    logic                 r_sync_err;

    logic [ACC_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [CW-1:0]        r_mem_chan [FIFO_DEPTH];
    logic [AW:0]          r_wr;
    logic [AW:0]          r_rd;

    logic                 w_take;
    logic                 w_resync;
    logic [CW-1:0]        w_slot;
    logic [ACC_WIDTH-1:0] w_base_acc;
    logic [NW-1:0]        w_base_cnt;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_dump;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;

    // A resync restarts every channel, so the current sample sees a zeroed
    // accumulator even though the registers clear on the same edge.
    always_comb begin
        w_take     = in_valid && ((r_state == S_RUN) || in_first);
        w_resync   = in_valid && in_first && (r_state == S_RUN) && (r_ch != '0);
        w_slot     = in_first ? '0 : r_ch;
        w_base_acc = w_resync ? '0 : r_acc[w_slot];
        w_base_cnt = w_resync ? '0 : r_cnt[w_slot];
        w_sum      = w_base_acc + ACC_WIDTH'(in_data);
        w_dump     = w_take && (w_base_cnt == NW'(BURST_LEN - 1));
        w_empty    = (r_wr == r_rd);
        w_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
        w_pop      = !w_empty && out_ready;
        w_push     = w_dump && (!w_full || w_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_ALIGN;
            r_ch       <= '0;
            r_overflow <= 1'b0;
            r_sync_err <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_take) begin
                if (w_resync) begin
                    r_sync_err <= 1'b1;
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        r_acc[i] <= '0;
                        r_cnt[i] <= '0;
                    end
                end
                if (w_dump) begin
                    r_acc[w_slot] <= '0;
                    r_cnt[w_slot] <= '0;
                end else begin
                    r_acc[w_slot] <= w_sum;
                    r_cnt[w_slot] <= w_base_cnt + NW'(1);
                end
                r_ch    <= (w_slot == CW'(NUM_CHANNELS - 1)) ? '0 : w_slot + CW'(1);
                r_state <= S_RUN;
            end
            if (w_dump && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + (AW+1)'(1);
            end
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr[AW-1:0]] <= w_sum;
            r_mem_chan[r_wr[AW-1:0]] <= w_slot;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem_data[r_rd[AW-1:0]];
    assign out_chan  = w_empty ? '0 : r_mem_chan[r_rd[AW-1:0]];
    assign aligned   = (r_state == S_RUN);
    assign overflow  = r_overflow;
    assign sync_err  = r_sync_err;

endmodule
`default_nettype wire
